// File: rtl/lsu_ctrl.sv
// Load/store request sequencer: latches one request, issues one memory strobe, returns one response.
// Latency store T+2, load T+3, fault T+1; a single request in flight, so o_req_ready is low until the response is taken.
module lsu_ctrl #(
  parameter int MEM_AW = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_func3,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_err,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [2:0]        o_mem_func3,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask_align,
  output logic [3:0]        o_mem_bmask_misalign,
  output logic              o_mem_wren,
  output logic              o_mem_rden,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t     state;
  logic       req_we_q;
  logic       accept;
  logic       req_err;
  logic [7:0] mask_wide;

  assign o_req_ready = (state == IDLE);
  assign accept      = i_req_valid && (state == IDLE);

  always_comb begin
    req_err = 1'b0;
    case (i_req_func3)
      3'b011, 3'b110, 3'b111: req_err = 1'b1;
      3'b100, 3'b101:         req_err = i_req_we;
      default:                req_err = 1'b0;
    endcase
    if ((i_req_addr >> MEM_AW) != 32'd0) req_err = 1'b1;
  end

  // Shifting the size pattern across two words yields {misalign, align} directly.
  always_comb begin
    mask_wide = 8'h00;
    case (i_req_func3[1:0])
      2'b00:   mask_wide = 8'h01 << i_req_addr[1:0];
      2'b01:   mask_wide = 8'h03 << i_req_addr[1:0];
      2'b10:   mask_wide = 8'h0F << i_req_addr[1:0];
      default: mask_wide = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state                <= IDLE;
      req_we_q             <= 1'b0;
      o_resp_valid         <= 1'b0;
      o_resp_err           <= 1'b0;
      o_resp_rdata         <= 32'd0;
      o_mem_addr           <= '0;
      o_mem_func3          <= 3'b000;
      o_mem_wdata          <= 32'd0;
      o_mem_bmask_align    <= 4'b0000;
      o_mem_bmask_misalign <= 4'b0000;
      o_mem_wren           <= 1'b0;
      o_mem_rden           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_we_q             <= i_req_we;
            o_mem_addr           <= i_req_addr[MEM_AW-1:0];
            o_mem_func3          <= i_req_func3;
            o_mem_wdata          <= i_req_wdata;
            o_mem_bmask_align    <= mask_wide[3:0];
            o_mem_bmask_misalign <= mask_wide[7:4];
            o_resp_rdata         <= 32'd0;
            if (req_err) begin
              state        <= RESP;
              o_resp_valid <= 1'b1;
              o_resp_err   <= 1'b1;
            end else begin
              state      <= ISSUE;
              o_mem_wren <= i_req_we;
              o_mem_rden <= !i_req_we;
            end
          end
        end
        ISSUE: begin
          o_mem_wren <= 1'b0;
          o_mem_rden <= 1'b0;
          if (req_we_q) begin
            state        <= RESP;
            o_resp_valid <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          o_resp_rdata <= i_mem_rdata;
          o_resp_valid <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (i_resp_ready) begin
            state        <= IDLE;
            o_resp_valid <= 1'b0;
            o_resp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: inputs driven and outputs sampled 1ns after each rising edge.
module tb_lsu_ctrl;
  localparam int MEM_AW = 16;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_we;
  logic [2:0]        i_req_func3;
  logic [31:0]       i_req_addr;
  logic [31:0]       i_req_wdata;
  logic              o_resp_valid;
  logic              i_resp_ready;
  logic [31:0]       o_resp_rdata;
  logic              o_resp_err;
  logic [MEM_AW-1:0] o_mem_addr;
  logic [2:0]        o_mem_func3;
  logic [31:0]       o_mem_wdata;
  logic [3:0]        o_mem_bmask_align;
  logic [3:0]        o_mem_bmask_misalign;
  logic              o_mem_wren;
  logic              o_mem_rden;
  logic [31:0]       i_mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  lsu_ctrl #(.MEM_AW(MEM_AW)) dut (
    .i_clk               (i_clk),
    .i_reset             (i_reset),
    .i_req_valid         (i_req_valid),
    .o_req_ready         (o_req_ready),
    .i_req_we            (i_req_we),
    .i_req_func3         (i_req_func3),
    .i_req_addr          (i_req_addr),
    .i_req_wdata         (i_req_wdata),
    .o_resp_valid        (o_resp_valid),
    .i_resp_ready        (i_resp_ready),
    .o_resp_rdata        (o_resp_rdata),
    .o_resp_err          (o_resp_err),
    .o_mem_addr          (o_mem_addr),
    .o_mem_func3         (o_mem_func3),
    .o_mem_wdata         (o_mem_wdata),
    .o_mem_bmask_align   (o_mem_bmask_align),
    .o_mem_bmask_misalign(o_mem_bmask_misalign),
    .o_mem_wren          (o_mem_wren),
    .o_mem_rden          (o_mem_rden),
    .i_mem_rdata         (i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Present one request for a single cycle, then scramble the request bus to prove it was latched.
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_func3 = f3;
    i_req_addr  = addr;
    i_req_wdata = wd;
    chk("req_ready_before_accept", {31'd0, o_req_ready}, 32'd1);
    step();
    i_req_valid = 1'b0;
    i_req_we    = ~we;
    i_req_func3 = 3'b111;
    i_req_addr  = 32'hFFFF_FFFF;
    i_req_wdata = ~wd;
  endtask

  initial begin
    i_reset      = 1'b0;
    i_req_valid  = 1'b0;
    i_req_we     = 1'b0;
    i_req_func3  = 3'b000;
    i_req_addr   = 32'd0;
    i_req_wdata  = 32'd0;
    i_resp_ready = 1'b1;
    i_mem_rdata  = 32'd0;

    step();
    step();
    chk("rst_resp_valid", {31'd0, o_resp_valid}, 32'd0);
    chk("rst_resp_err",   {31'd0, o_resp_err},   32'd0);
    chk("rst_wren",       {31'd0, o_mem_wren},   32'd0);
    chk("rst_rden",       {31'd0, o_mem_rden},   32'd0);
    chk("rst_rdata",      o_resp_rdata,          32'd0);
    chk("rst_addr",       {16'd0, o_mem_addr},   32'd0);
    chk("rst_wdata",      o_mem_wdata,           32'd0);
    chk("rst_masks",      {24'd0, o_mem_bmask_misalign, o_mem_bmask_align}, 32'd0);
    chk("rst_func3",      {29'd0, o_mem_func3},  32'd0);
    chk("rst_ready",      {31'd0, o_req_ready},  32'd1);
    i_reset = 1'b1;
    step();

    // SW 0x104
    send(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF);
    chk("sw_wren",      {31'd0, o_mem_wren},  32'd1);
    chk("sw_rden",      {31'd0, o_mem_rden},  32'd0);
    chk("sw_addr",      {16'd0, o_mem_addr},  32'h0104);
    chk("sw_masks",     {24'd0, o_mem_bmask_misalign, o_mem_bmask_align}, 32'h0F);
    chk("sw_wdata",     o_mem_wdata,          32'hDEAD_BEEF);
    chk("sw_func3",     {29'd0, o_mem_func3}, 32'd2);
    chk("sw_ready_busy", {31'd0, o_req_ready}, 32'd0);
    chk("sw_no_resp_t1", {31'd0, o_resp_valid}, 32'd0);
    step();
    chk("sw_resp_valid", {31'd0, o_resp_valid}, 32'd1);
    chk("sw_resp_err",   {31'd0, o_resp_err},   32'd0);
    chk("sw_resp_rdata", o_resp_rdata,          32'd0);
    chk("sw_wren_off",   {31'd0, o_mem_wren},   32'd0);
    chk("sw_addr_hold",  {16'd0, o_mem_addr},   32'h0104);
    step();
    chk("sw_idle_ready", {31'd0, o_req_ready},  32'd1);
    chk("sw_idle_valid", {31'd0, o_resp_valid}, 32'd0);

    // LW 0x106 with a held response and an ignored request during RESP
    i_resp_ready = 1'b0;
    send(1'b0, 3'b010, 32'h0000_0106, 32'd0);
    chk("lw_rden",  {31'd0, o_mem_rden}, 32'd1);
    chk("lw_wren",  {31'd0, o_mem_wren}, 32'd0);
    chk("lw_masks", {24'd0, o_mem_bmask_misalign, o_mem_bmask_align}, 32'h3C);
    step();
    i_mem_rdata = 32'h1234_5678;
    chk("lw_rden_off_wait", {31'd0, o_mem_rden},   32'd0);
    chk("lw_no_resp_t2",    {31'd0, o_resp_valid}, 32'd0);
    step();
    i_mem_rdata = 32'hA5A5_A5A5;
    chk("lw_resp_valid", {31'd0, o_resp_valid}, 32'd1);
    chk("lw_resp_rdata", o_resp_rdata,          32'h1234_5678);
    chk("lw_resp_err",   {31'd0, o_resp_err},   32'd0);
    i_req_valid = 1'b1;
    i_req_we    = 1'b1;
    i_req_func3 = 3'b010;
    i_req_addr  = 32'h0000_0200;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", {31'd0, o_resp_valid}, 32'd1);
      chk("hold_rdata", o_resp_rdata,          32'h1234_5678);
      chk("hold_ready", {31'd0, o_req_ready},  32'd0);
      chk("hold_wren",  {31'd0, o_mem_wren},   32'd0);
      chk("hold_addr",  {16'd0, o_mem_addr},   32'h0106);
    end
    i_req_valid  = 1'b0;
    i_resp_ready = 1'b1;
    step();
    chk("hold_release_ready", {31'd0, o_req_ready},  32'd1);
    chk("hold_release_valid", {31'd0, o_resp_valid}, 32'd0);

    // SH 0x3 (crosses into next word)
    send(1'b1, 3'b001, 32'h0000_0003, 32'h0000_ABCD);
    chk("sh_masks", {24'd0, o_mem_bmask_misalign, o_mem_bmask_align}, 32'h18);
    chk("sh_wren",  {31'd0, o_mem_wren}, 32'd1);
    chk("sh_wdata", o_mem_wdata,         32'h0000_ABCD);
    step();
    step();

    // SB 0x2
    send(1'b1, 3'b000, 32'h0000_0002, 32'h0000_005A);
    chk("sb_masks", {24'd0, o_mem_bmask_misalign, o_mem_bmask_align}, 32'h04);
    chk("sb_wren",  {31'd0, o_mem_wren}, 32'd1);
    step();
    step();

    // LHU 0x1: data passes through unchanged
    send(1'b0, 3'b101, 32'h0000_0001, 32'd0);
    chk("lhu_masks", {24'd0, o_mem_bmask_misalign, o_mem_bmask_align}, 32'h06);
    chk("lhu_rden",  {31'd0, o_mem_rden}, 32'd1);
    step();
    i_mem_rdata = 32'hFFFF_8001;
    step();
    chk("lhu_rdata", o_resp_rdata,        32'hFFFF_8001);
    chk("lhu_err",   {31'd0, o_resp_err}, 32'd0);
    step();

    // LW out of range
    send(1'b0, 3'b010, 32'h0001_0000, 32'd0);
    chk("oor_valid", {31'd0, o_resp_valid}, 32'd1);
    chk("oor_err",   {31'd0, o_resp_err},   32'd1);
    chk("oor_rdata", o_resp_rdata,          32'd0);
    chk("oor_strb",  {30'd0, o_mem_wren, o_mem_rden}, 32'd0);
    step();
    chk("oor_ready", {31'd0, o_req_ready}, 32'd1);
    chk("oor_strb2", {30'd0, o_mem_wren, o_mem_rden}, 32'd0);

    // funct3 = 011
    send(1'b0, 3'b011, 32'h0000_0010, 32'd0);
    chk("f3_011_err",  {31'd0, o_resp_err},   32'd1);
    chk("f3_011_valid", {31'd0, o_resp_valid}, 32'd1);
    chk("f3_011_strb", {30'd0, o_mem_wren, o_mem_rden}, 32'd0);
    step();

    // store with load-only funct3
    send(1'b1, 3'b100, 32'h0000_0010, 32'h1111_1111);
    chk("sbu_err",  {31'd0, o_resp_err}, 32'd1);
    chk("sbu_strb", {30'd0, o_mem_wren, o_mem_rden}, 32'd0);
    step();

    // reset during ISSUE drops the strobe immediately
    send(1'b0, 3'b010, 32'h0000_0040, 32'd0);
    chk("rst_issue_rden_pre", {31'd0, o_mem_rden}, 32'd1);
    #2 i_reset = 1'b0;
    #1;
    chk("rst_issue_rden", {31'd0, o_mem_rden},  32'd0);
    chk("rst_issue_ready", {31'd0, o_req_ready}, 32'd1);
    step();
    i_reset = 1'b1;
    step();

    // reset during WAIT aborts with no response
    send(1'b0, 3'b010, 32'h0000_0008, 32'd0);
    step();
    chk("wait_ready",  {31'd0, o_req_ready},  32'd0);
    chk("wait_nvalid", {31'd0, o_resp_valid}, 32'd0);
    #2 i_reset = 1'b0;
    #1;
    chk("rst_wait_valid", {31'd0, o_resp_valid}, 32'd0);
    chk("rst_wait_ready", {31'd0, o_req_ready},  32'd1);
    chk("rst_wait_addr",  {16'd0, o_mem_addr},   32'd0);
    chk("rst_wait_masks", {24'd0, o_mem_bmask_misalign, o_mem_bmask_align}, 32'd0);
    chk("rst_wait_func3", {29'd0, o_mem_func3},  32'd0);
    chk("rst_wait_rdata", o_resp_rdata,          32'd0);
    step();
    step();
    chk("rst_wait_still_nvalid", {31'd0, o_resp_valid}, 32'd0);
    i_reset = 1'b1;
    step();
    chk("post_rst_ready", {31'd0, o_req_ready}, 32'd1);
    send(1'b1, 3'b010, 32'h0000_0020, 32'h1122_3344);
    chk("post_rst_wren", {31'd0, o_mem_wren}, 32'd1);
    chk("post_rst_addr", {16'd0, o_mem_addr}, 32'h0020);
    step();
    chk("post_rst_resp", {31'd0, o_resp_valid}, 32'd1);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
